mux_arb: RTL
============

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter DATAW, default 67, flit width in bits; flit type field is idata_N[DATAW-1 -: TYPEW].
REQ-002 Parameter TYPEW, default 3, flit type field width.
REQ-003 Parameter MAXLEN, default 32, maximum transferred flits per packet, HEAD and TAIL included; range 2..255.
REQ-004 Type encodings SHALL be NONE=0, HEAD=1, DATA=2, TAIL=3; all other codes are treated as DATA.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 idata_0  in  DATAW  port-0 flit, sampled only for its type field.
REQ-008 ivalid_0  in  1  port-0 flit valid.
REQ-009 idata_1  in  DATAW  port-1 flit, sampled only for its type field.
REQ-010 ivalid_1  in  1  port-1 flit valid.
REQ-011 ordy  in  1  downstream can accept a flit this cycle.
REQ-012 sel  out  1  mux select: 0 routes port 0 to odata, 1 routes port 1.
REQ-013 iready_0  out  1  port-0 flit consumed this cycle.
REQ-014 iready_1  out  1  port-1 flit consumed this cycle.
REQ-015 lock  out  1  a packet currently owns the mux.
REQ-016 err  out  1  one-cycle pulse on packet-length overrun abort.

Function
REQ-017 FSM states SHALL be IDLE, LOCK0 and LOCK1, with a registered 1-bit round-robin pointer prio naming the preferred port.
REQ-018 req_N SHALL be ivalid_N AND type_N==HEAD; in IDLE, non-HEAD flits are ignored and never get iready.
REQ-019 IDLE, exactly one req_N -> LOCKN at the next edge.
REQ-020 IDLE, both req -> LOCK(prio) at the next edge.
REQ-021 IDLE, no req -> stay in IDLE.
REQ-022 Grant latency SHALL be one cycle: a HEAD presented at cycle t is eligible for transfer at t+1 at the earliest.
REQ-023 sel SHALL be registered: 0 in LOCK0, 1 in LOCK1, and hold its last value in IDLE.
REQ-024 iready_N SHALL equal (state==LOCKN) AND ordy, combinationally from ordy; iready of the other port SHALL be 0.
REQ-025 A transfer SHALL occur on a cycle with ivalid_N AND iready_N; a stalled flit (ordy=0) is not counted.
REQ-026 Flit counter cnt (8 bits) SHALL clear on entry to LOCKN and increment by 1 per transfer.
REQ-027 A TAIL transfer in LOCKN -> IDLE at the next edge, with prio set to the other port (1-N) at the same edge.
REQ-028 A transfer with cnt==MAXLEN-1 that is not TAIL -> IDLE at the next edge, prio set to 1-N, and err=1 for that one cycle.
REQ-029 When TAIL and the MAXLEN limit coincide, the packet is normal: no err.
REQ-030 A HEAD received while locked on the owning port SHALL be counted as DATA; no re-arbitration.
REQ-031 A request on the non-owning port while locked SHALL wait, with no state effect.
REQ-032 In IDLE, iready_0=iready_1=0 and lock=0; in LOCKN, lock=1.
REQ-033 Back-to-back packets: after the TAIL edge, one IDLE cycle SHALL always separate grants (arbitration bubble).
REQ-034 ivalid_N=0 while locked SHALL hold the state and the counter (gaps allowed mid-packet).

Reset
REQ-035 rst=1 at an edge SHALL force state=IDLE, prio=0, cnt=0, sel=0 and err=0, overriding all other events.
REQ-036 Reset mid-packet SHALL abandon the lock with no err pulse; the first grant after reset follows the IDLE rules.
REQ-037 While rst=1: iready_0=iready_1=0 and lock=0.

Verification
REQ-038 Reset, then at t0 port 1 HEAD, DATA×20, TAIL with ordy=1 -> sel=1 and lock=1 from t0+1, iready_1=1 for 22 cycles, IDLE at TAIL+1, prio=0, err=0.
REQ-039 Both ports present HEAD at the same cycle after reset -> port 0 granted first; after its TAIL, one IDLE cycle, then port 1 granted; then prio=0.
REQ-040 Granted on port 0, ordy toggles 1,0,0,1 across a 4-flit packet -> iready_0 follows ordy, cnt advances only on ordy=1, TAIL consumed at the 6th cycle of the lock.
REQ-041 MAXLEN=4, port 0 sends HEAD plus 5 DATA -> 4 transfers, err=1 for exactly one cycle after the 4th, IDLE, 5th DATA not consumed; with TAIL as 4th flit, err=0.
REQ-042 rst pulsed at the 3rd DATA of a port-1 packet -> next cycle IDLE, sel=0, lock=0, err=0; a DATA flit on port 0 in IDLE never gets iready_0.

Source files
------------

// File: rtl/mux_arb.sv
// Two-port packet arbiter for a flit mux: grants one port per HEAD..TAIL packet,
// round-robin between simultaneous requests, aborts packets that exceed MAXLEN flits.
module mux_arb #(
    parameter int DATAW  = 67,
    parameter int TYPEW  = 3,
    parameter int MAXLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata_0,
    input  logic             ivalid_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic             ivalid_1,
    input  logic             ordy,
    output logic             sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             lock,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [TYPEW-1:0] T_HEAD   = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL   = TYPEW'(3);
    localparam logic [7:0]       CNT_LAST = 8'(MAXLEN - 1);

    state_t     state, state_nxt;
    logic       prio, prio_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       sel_nxt;
    logic       err_nxt;

    logic [TYPEW-1:0] type_0, type_1;
    logic             req_0, req_1;
    logic             xfer, xfer_tail;

    // Only the type field steers arbitration; payload bits pass through the external mux.
    logic unused_payload;
    assign unused_payload = ^{idata_0[DATAW-TYPEW-1:0], idata_1[DATAW-TYPEW-1:0]};

    assign type_0 = idata_0[DATAW-1 -: TYPEW];
    assign type_1 = idata_1[DATAW-1 -: TYPEW];
    assign req_0  = ivalid_0 && (type_0 == T_HEAD);
    assign req_1  = ivalid_1 && (type_1 == T_HEAD);

    assign iready_0  = (state == LOCK0) && ordy && !rst;
    assign iready_1  = (state == LOCK1) && ordy && !rst;
    assign lock      = (state != IDLE) && !rst;
    assign xfer      = (ivalid_0 && iready_0) || (ivalid_1 && iready_1);
    assign xfer_tail = (state == LOCK1) ? (type_1 == T_TAIL) : (type_0 == T_TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= 8'd0;
            sel   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req_0 && (!req_1 || !prio)) begin
                    state_nxt = LOCK0;
                    sel_nxt   = 1'b0;
                    cnt_nxt   = 8'd0;
                end else if (req_1) begin
                    state_nxt = LOCK1;
                    sel_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                end
            end
            LOCK0, LOCK1: begin
                // A TAIL landing exactly on the length limit is a normal end, not an abort.
                if (xfer) begin
                    cnt_nxt = cnt + 8'd1;
                    if (xfer_tail) begin
                        state_nxt = IDLE;
                        prio_nxt  = (state == LOCK0);
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        prio_nxt  = (state == LOCK0);
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
